// File: rtl/memory_stage.sv
// Memory-access stage: carries loads/stores to the data bus, stalls execute while a bus access is pending,
// and aborts hung accesses via a watchdog. Optional MEM_ALIGN_CHECK_EN rejects misaligned memory ops.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        rf_we_i,
    input  logic        mem_we_i,
    input  logic        mem2rf_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [31:0] rf_waddr_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        rf_we_o,
    output logic [31:0] rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        err_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        cap_store, cap_rf_we;
    logic [31:0] cap_addr, cap_wdata, cap_waddr;
    logic        wb_valid_n, rf_we_n, err_n;
    logic [31:0] rf_waddr_n, rf_wdata_n;
    logic        mem_op, misaligned, transfer, done;

    assign mem_op   = mem_we_i | mem2rf_i;
    assign transfer = valid_i && (state == IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op && (alu_result_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign ready_o      = (state == IDLE);
    assign dmem_req_o   = (state == REQ);
    assign dmem_we_o    = (state == REQ) && cap_store;
    assign dmem_addr_o  = cap_addr;
    assign dmem_wdata_o = cap_wdata;

    // A store completes on grant; a load needs rvalid, either with the grant or later in WAIT.
    assign done = ((state == REQ) && dmem_gnt_i && (cap_store || dmem_rvalid_i)) ||
                  ((state == WAIT) && dmem_rvalid_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_store <= 1'b0;
            cap_rf_we <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_waddr <= '0;
        end else if (transfer) begin
            cap_store <= mem_we_i;
            cap_rf_we <= rf_we_i && !(mem_we_i && mem2rf_i);
            cap_addr  <= alu_result_i;
            cap_wdata <= mem_wdata_i;
            cap_waddr <= rf_waddr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wb_valid_o <= 1'b0;
            rf_we_o    <= 1'b0;
            err_o      <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wb_valid_o <= wb_valid_n;
            rf_we_o    <= rf_we_n;
            err_o      <= err_n;
            rf_waddr_o <= rf_waddr_n;
            rf_wdata_o <= rf_wdata_n;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= transfer && misaligned;
        end
    end
`else
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        wb_valid_n = 1'b0;
        rf_we_n    = 1'b0;
        err_n      = 1'b0;
        rf_waddr_n = rf_waddr_o;
        rf_wdata_n = rf_wdata_o;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (!mem_op || misaligned) begin
                        wb_valid_n = 1'b1;
                        rf_we_n    = rf_we_i && !mem_op;
                        rf_waddr_n = rf_waddr_i;
                        rf_wdata_n = alu_result_i;
                    end else begin
                        state_n = REQ;
                        cnt_n   = '0;
                    end
                end
            end
            REQ, WAIT: begin
                if (done) begin
                    state_n    = IDLE;
                    wb_valid_n = 1'b1;
                    rf_we_n    = cap_rf_we;
                    rf_waddr_n = cap_waddr;
                    rf_wdata_n = cap_store ? cap_addr : dmem_rdata_i;
                end else if (cnt == CNT_LAST) begin
                    state_n    = IDLE;
                    wb_valid_n = 1'b1;
                    err_n      = 1'b1;
                    rf_waddr_n = cap_waddr;
                end else begin
                    cnt_n = cnt + 8'd1;
                    if ((state == REQ) && dmem_gnt_i) begin
                        state_n = WAIT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the pipelined RISC-V core, sitting directly after execute and consuming its outputs: ALU result, store data, register-file write address and the rf/mem/mem2rf control bits. Carries loads and stores to the data-memory bus over a request/grant/rvalid handshake and stalls execute while a bus access is pending. Emits registered write-back results. A timeout watchdog turns a hung bus access into an error pulse instead of a permanent stall.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ+WAIT before abort; legal range 2..255.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  execute outputs below are valid this cycle.
- ready_o  out  1  stage accepts a transfer; a transfer occurs when valid_i && ready_o.
- rf_we_i, mem_we_i, mem2rf_i  in  1 each  control bits from execute.
- alu_result_i  in  32  ALU result; the memory address for loads and stores.
- mem_wdata_i  in  32  store data.
- rf_waddr_i  in  32  destination register address, passed through.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o, dmem_wdata_o  out  32 each  bus address and store data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  32  load data.
- wb_valid_o  out  1  one-cycle pulse: write-back outputs are valid.
- rf_we_o  out  1  register-file write enable, qualified by wb_valid_o.
- rf_waddr_o, rf_wdata_o  out  32 each  write-back address and data.
- err_o  out  1  one-cycle pulse on timeout abort.
- misalign_o  out  1  one-cycle pulse on a misaligned access; constant 0 without the macro.

## Operation
- FSM states: IDLE, REQ, WAIT. ready_o = (state == IDLE).
- IDLE, transfer of a non-memory op (mem_we_i = 0, mem2rf_i = 0): capture the inputs and stay in IDLE. Next cycle: wb_valid_o = 1, rf_we_o = rf_we_i, rf_wdata_o = alu_result_i.
- IDLE, transfer of a memory op: capture the inputs and go to REQ. If mem_we_i and mem2rf_i are both 1, the op is treated as a store and the write-back has rf_we_o forced to 0.
- REQ: dmem_req_o = 1. dmem_addr_o, dmem_we_o and dmem_wdata_o stay stable until the grant.
  - Store + gnt: go to IDLE; next cycle wb_valid_o = 1 with the captured rf_we.
  - Load + gnt without rvalid: go to WAIT.
  - Load + gnt + rvalid in the same cycle: complete immediately with rf_wdata_o = dmem_rdata_i.
  - rvalid without gnt: ignored.
- WAIT: dmem_req_o = 0. On rvalid: rf_wdata_o = dmem_rdata_i, rf_we_o = captured rf_we, wb_valid_o pulses next cycle, go to IDLE.
- Watchdog: an 8-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES-1 with no completion that cycle: go to IDLE; next cycle err_o = 1, wb_valid_o = 1, rf_we_o = 0. A completion in the same cycle as the timeout wins: normal write-back, no err_o.
- Address and data are never modified; no byte or half-word lanes.

## Timing
- Reset (rst_n low): state IDLE, counter 0; dmem_req_o, dmem_we_o, wb_valid_o, rf_we_o, err_o, misalign_o = 0; all 32-bit outputs 0; ready_o = 1.
- Reset in REQ or WAIT drops dmem_req_o asynchronously and abandons the op; a late rvalid after reset is ignored.
- All outputs are registered except ready_o and the dmem_* request signals, which are decoded from the state register and the captured registers.
- Latency, non-memory op: 1 cycle. Store: gnt cycle + 1. Load: rvalid cycle + 1.
- Back-to-back non-memory ops sustain one per cycle; a memory op blocks the next transfer until return to IDLE.

## Configuration
- MEM_ALIGN_CHECK_EN defined: a memory op with alu_result_i[1:0] != 0 never enters REQ and issues no bus request. Next cycle: wb_valid_o = 1, rf_we_o = 0, misalign_o = 1.
- MEM_ALIGN_CHECK_EN undefined: no check; the address goes to the bus unchanged and misalign_o is tied to 0.

## Test plan
- ALU op rf_we_i = 1, alu_result_i = 0x1234, rf_waddr_i = 5 → next cycle wb_valid_o = 1, rf_we_o = 1, rf_wdata_o = 0x1234, rf_waddr_o = 5; three back-to-back ops → three consecutive pulses.
- Store to 0x100, data 0xDEADBEEF, gnt delayed 3 cycles → dmem_req_o held 4 cycles with stable addr/data, ready_o = 0 throughout; wb_valid_o = 1 with rf_we_o = 0 one cycle after gnt.
- Load from 0x40, gnt + rvalid in the same cycle with rdata 0xCAFEF00D → wb_valid_o next cycle, rf_wdata_o = 0xCAFEF00D; then gnt followed 2 cycles later by rvalid → WAIT path, same result.
- Load granted but never answered, TIMEOUT_CYCLES = 4 → err_o and wb_valid_o with rf_we_o = 0 exactly 4 cycles after REQ entry; ready_o = 1 the following cycle.
- rst_n pulsed low while in WAIT, then rvalid asserted → all outputs 0, no wb_valid_o, ready_o = 1.
- With MEM_ALIGN_CHECK_EN, load from 0x102 → no dmem_req_o; next cycle misalign_o = 1, wb_valid_o = 1, rf_we_o = 0.
